// File: rtl/sdram_chip_model.sv
// sdram_chip_model: SDRAM command-bus responder with bank tracking, CAS-latency read pipeline and a small backing RAM.
// Optional timing checks (tRCD/tRP/tRC into err[3]) are enabled by SDRAM_MODEL_TIMING_CHECK_EN.
module sdram_chip_model #(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sd_cs,
    input  logic        sd_ras,
    input  logic        sd_cas,
    input  logic        sd_we,
    input  logic [1:0]  sd_ba,
    input  logic [12:0] sd_addr,
    input  logic [1:0]  sd_dqm,
    input  logic [15:0] sd_data_in,
    output logic [15:0] sd_data_out,
    output logic        sd_data_oe,
    output logic [12:0] mode_reg,
    output logic        mode_valid,
    output logic [3:0]  err
);
    localparam int AW = 2 + ROW_BITS + COL_BITS;

    logic [3:0] cmd;
    logic nop, act, rd, wr, pre, ref_c, lmr, bst;
    logic mode_err, cl_bad, rw_ok, rw_closed, act_ok, act_open, ref_open, t_viol;
    logic cl3;
    logic [3:0] bl;
    logic [3:0] bank_open, bo_n;
    logic [ROW_BITS-1:0] row [4];
    logic [15:0] ram [2**AW];

    logic b_act, b_wr, b_ap;
    logic [1:0] b_ba;
    logic [COL_BITS-1:0] b_col;
    logic [2:0] b_beat;
    logic [3:0] b_len;

    logic start, cont, go, last, o_wr, o_ap;
    logic [1:0] o_ba;
    logic [COL_BITS-1:0] o_col, col_k;
    logic [2:0] o_k, mask;
    logic [3:0] o_len;
    logic [AW-1:0] idx;

    logic [2:0] v;
    logic [15:0] rd_q, s1, s2;

    assign cmd   = {sd_cs, sd_ras, sd_cas, sd_we};
    assign nop   = sd_cs || cmd == 4'b0111;
    assign act   = cmd == 4'b0011;
    assign rd    = cmd == 4'b0101;
    assign wr    = cmd == 4'b0100;
    assign pre   = cmd == 4'b0010;
    assign ref_c = cmd == 4'b0001;
    assign lmr   = cmd == 4'b0000;
    assign bst   = cmd == 4'b0110;

    assign cl3 = mode_reg[6:4] == 3'd3;
    assign bl  = mode_reg[2] ? 4'd1 : 4'd1 << mode_reg[1:0];

    assign mode_err  = !mode_valid && !(nop || pre || lmr);
    assign cl_bad    = lmr && !(sd_addr[6:4] == 3'd2 || sd_addr[6:4] == 3'd3);
    assign rw_ok     = (rd || wr) && mode_valid && bank_open[sd_ba];
    assign rw_closed = (rd || wr) && mode_valid && !bank_open[sd_ba];
    assign act_ok    = act && mode_valid && !bank_open[sd_ba];
    assign act_open  = act && mode_valid && bank_open[sd_ba];
    assign ref_open  = ref_c && mode_valid && |bank_open;

    // A fresh READ/WRITE takes priority over (and truncates) any burst in progress.
    assign start = rw_ok;
    assign cont  = !start && b_act && !bst;
    assign go    = start || cont;
    assign o_ba  = start ? sd_ba : b_ba;
    assign o_col = start ? sd_addr[COL_BITS-1:0] : b_col;
    assign o_wr  = start ? wr : b_wr;
    assign o_ap  = start ? sd_addr[10] : b_ap;
    assign o_k   = start ? 3'd0 : b_beat;
    assign o_len = start ? ((wr && mode_reg[9]) ? 4'd1 : bl) : b_len;
    assign last  = go && {1'b0, o_k} == o_len - 4'd1;
    assign mask  = o_len[2:0] - 3'd1;
    assign col_k = (o_col & ~COL_BITS'(mask)) | ((o_col + COL_BITS'(o_k)) & COL_BITS'(mask));
    assign idx   = {o_ba, row[o_ba], col_k};

    always_comb begin
        bo_n = bank_open;
        if (pre) bo_n = sd_addr[10] ? 4'b0 : bo_n & ~(4'b1 << sd_ba);
        if (last && o_ap) bo_n[o_ba] = 1'b0;
        if (act_ok) bo_n[sd_ba] = 1'b1;
    end

`ifdef SDRAM_MODEL_TIMING_CHECK_EN
    logic [1:0] rcd [4];
    logic [1:0] rp [4];
    logic [2:0] rc;

    // Counters hold cycles since the last event and saturate once the constraint is met.
    assign t_viol = ((rd || wr) && rcd[sd_ba] < 2'd2) || (act && rp[sd_ba] < 2'd2) || (!nop && rc < 3'd4);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 4; b++) begin
                rcd[b] <= 2'd3;
                rp[b]  <= 2'd3;
            end
            rc <= 3'd7;
        end else begin
            for (int b = 0; b < 4; b++) begin
                rcd[b] <= (act && sd_ba == 2'(b)) ? 2'd1 : (rcd[b] == 2'd3 ? rcd[b] : rcd[b] + 2'd1);
                rp[b]  <= ((pre && (sd_addr[10] || sd_ba == 2'(b))) || (last && o_ap && o_ba == 2'(b))) ? 2'd1
                          : (rp[b] == 2'd3 ? rp[b] : rp[b] + 2'd1);
            end
            rc <= ref_c ? 3'd1 : (rc == 3'd7 ? rc : rc + 3'd1);
        end
    end
`else
    assign t_viol = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (go && o_wr && !sd_dqm[0]) ram[idx][7:0]  <= sd_data_in[7:0];
        if (go && o_wr && !sd_dqm[1]) ram[idx][15:8] <= sd_data_in[15:8];
        rd_q <= ram[idx];
        s1   <= rd_q;
        s2   <= s1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sd_data_out <= 16'h0;
            sd_data_oe  <= 1'b0;
            mode_reg    <= 13'h0;
            mode_valid  <= 1'b0;
            err         <= 4'h0;
            bank_open   <= 4'h0;
            for (int b = 0; b < 4; b++) row[b] <= '0;
            b_act  <= 1'b0;
            b_wr   <= 1'b0;
            b_ap   <= 1'b0;
            b_ba   <= 2'd0;
            b_col  <= '0;
            b_beat <= 3'd0;
            b_len  <= 4'd0;
            v      <= 3'b0;
        end else begin
            err <= err | {t_viol, act_open || ref_open, rw_closed, mode_err || cl_bad};
            if (lmr) begin
                mode_reg   <= sd_addr;
                mode_valid <= 1'b1;
            end
            bank_open <= bo_n;
            if (act_ok) row[sd_ba] <= sd_addr[ROW_BITS-1:0];
            b_act  <= go && !last;
            b_beat <= o_k + 3'd1;
            if (start) begin
                b_wr  <= wr;
                b_ap  <= sd_addr[10];
                b_ba  <= sd_ba;
                b_col <= sd_addr[COL_BITS-1:0];
                b_len <= o_len;
            end
            // v[0] marks a beat read from RAM this edge; the output tap selects CL.
            v           <= {v[1:0], go && !o_wr};
            sd_data_oe  <= cl3 ? v[2] : v[1];
            sd_data_out <= cl3 ? (v[2] ? s2 : 16'h0) : (v[1] ? s1 : 16'h0);
        end
    end
endmodule

// File: tb/tb_sdram_chip_model.sv
// tb_sdram_chip_model: scoreboard bench; expected read beats are queued with their due cycle when READ is issued.
module tb_sdram_chip_model;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sd_cs = 1'b1, sd_ras = 1'b1, sd_cas = 1'b1, sd_we = 1'b1;
    logic [1:0]  sd_ba = 2'd0;
    logic [12:0] sd_addr = 13'h0;
    logic [1:0]  sd_dqm = 2'b0;
    logic [15:0] sd_data_in = 16'h0;
    logic [15:0] sd_data_out;
    logic        sd_data_oe;
    logic [12:0] mode_reg;
    logic        mode_valid;
    logic [3:0]  err;

    localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100,
                           PRE = 4'b0010, LMR = 4'b0000;
`ifdef SDRAM_MODEL_TIMING_CHECK_EN
    localparam logic TCHK = 1'b1;
`else
    localparam logic TCHK = 1'b0;
`endif

    typedef struct {
        logic [15:0] d;
        int          c;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests = 0, fails = 0, cyc = 0, cl = 2, edge_cyc = 0;
    bit   mon_en = 1'b1;

    sdram_chip_model dut (
        .clk(clk), .reset(reset), .sd_cs(sd_cs), .sd_ras(sd_ras), .sd_cas(sd_cas), .sd_we(sd_we),
        .sd_ba(sd_ba), .sd_addr(sd_addr), .sd_dqm(sd_dqm), .sd_data_in(sd_data_in),
        .sd_data_out(sd_data_out), .sd_data_oe(sd_data_oe), .mode_reg(mode_reg),
        .mode_valid(mode_valid), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                         input logic [1:0] dqm, input logic [15:0] d);
        {sd_cs, sd_ras, sd_cas, sd_we} = c;
        sd_ba = ba;
        sd_addr = a;
        sd_dqm = dqm;
        sd_data_in = d;
        edge_cyc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic nops(input int n);
        repeat (n) issue(NOP, 2'd0, 13'h0, 2'b0, 16'h0);
    endtask

    task automatic expect_beat(input int k, input logic [15:0] d);
        sb.push_back('{d: d, c: edge_cyc + cl + k});
    endtask

    always @(negedge clk) begin
        if (mon_en && sd_data_oe) begin
            if (sb.size() == 0) check("spurious_oe", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                check("rd_data", 32'(sd_data_out), 32'(e.d));
                check("rd_edge", cyc, e.c);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_dout", 32'(sd_data_out), 32'h0);
        check("rst_oe", 32'(sd_data_oe), 32'h0);
        check("rst_mode", 32'(mode_reg), 32'h0);
        check("rst_mvalid", 32'(mode_valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        reset = 1'b0;
        issue(PRE, 2'd0, 13'h400, 2'b0, 16'h0);
        issue(LMR, 2'd0, 13'h220, 2'b0, 16'h0);
        nops(1);
        check("init_mvalid", 32'(mode_valid), 32'h1);
        check("init_mode", 32'(mode_reg), 32'h220);
        check("init_err", 32'(err), 32'h0);
        cl = 2;
        issue(ACT, 2'd1, 13'h005, 2'b0, 16'h0);
        nops(1);
        issue(WR, 2'd1, 13'h403, 2'b00, 16'hA5A5);
        nops(2);
        issue(ACT, 2'd1, 13'h005, 2'b0, 16'h0);
        nops(2);
        issue(RD, 2'd1, 13'h003, 2'b0, 16'h0);
        expect_beat(0, 16'hA5A5);
        nops(4);
        check("oe_idle1", 32'(sd_data_oe), 32'h0);
        issue(WR, 2'd1, 13'h003, 2'b01, 16'h1234);
        nops(1);
        issue(RD, 2'd1, 13'h003, 2'b0, 16'h0);
        expect_beat(0, 16'h12A5);
        nops(4);
        issue(LMR, 2'd0, 13'h032, 2'b0, 16'h0);
        cl = 3;
        nops(1);
        issue(WR, 2'd1, 13'h006, 2'b0, 16'd1);
        for (int i = 2; i <= 4; i++) issue(NOP, 2'd0, 13'h0, 2'b0, 16'(i));
        issue(RD, 2'd1, 13'h006, 2'b0, 16'h0);
        for (int k = 0; k < 4; k++) expect_beat(k, 16'(k + 1));
        nops(8);
        issue(RD, 2'd1, 13'h004, 2'b0, 16'h0);
        expect_beat(0, 16'd3);
        expect_beat(1, 16'd4);
        expect_beat(2, 16'd1);
        expect_beat(3, 16'd2);
        nops(8);
        check("oe_idle2", 32'(sd_data_oe), 32'h0);
        issue(RD, 2'd2, 13'h000, 2'b0, 16'h0);
        nops(4);
        check("closed_oe", 32'(sd_data_oe), 32'h0);
        check("closed_err1", 32'(err[1]), 32'h1);
        issue(ACT, 2'd1, 13'h005, 2'b0, 16'h0);
        nops(1);
        check("open_err2", 32'(err[2]), 32'h1);
        check("no_err0", 32'(err[0]), 32'h0);
        issue(LMR, 2'd0, 13'h020, 2'b0, 16'h0);
        cl = 2;
        nops(1);
        issue(ACT, 2'd0, 13'h001, 2'b0, 16'h0);
        nops(1);
        issue(WR, 2'd0, 13'h400, 2'b0, 16'hBEEF);
        nops(2);
        issue(ACT, 2'd0, 13'h001, 2'b0, 16'h0);
        issue(RD, 2'd0, 13'h000, 2'b0, 16'h0);
        expect_beat(0, 16'hBEEF);
        nops(4);
        check("trcd_err3", 32'(err[3]), 32'(TCHK));
        issue(LMR, 2'd0, 13'h050, 2'b0, 16'h0);
        nops(1);
        check("badcl_err0", 32'(err[0]), 32'h1);
        issue(RD, 2'd0, 13'h000, 2'b0, 16'h0);
        expect_beat(0, 16'hBEEF);
        nops(4);
        check("err_final", 32'(err), 32'({TCHK, 3'b111}));
        issue(LMR, 2'd0, 13'h023, 2'b0, 16'h0);
        nops(1);
        mon_en = 1'b0;
        issue(RD, 2'd0, 13'h000, 2'b0, 16'h0);
        nops(2);
        check("burst_oe", 32'(sd_data_oe), 32'h1);
        reset = 1'b1;
        #1;
        check("mid_rst_oe", 32'(sd_data_oe), 32'h0);
        check("mid_rst_dout", 32'(sd_data_out), 32'h0);
        check("mid_rst_mvalid", 32'(mode_valid), 32'h0);
        check("mid_rst_err", 32'(err), 32'h0);
        repeat (3) @(negedge clk);
        check("rst_hold_oe", 32'(sd_data_oe), 32'h0);
        reset = 1'b0;
        nops(2);
        mon_en = 1'b1;
        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
